// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   regbits_t    : register select (5 bits, 32 registers)
//   word_t       : register word (32 bits)
//   dump_state_t : register dump sequencer states
package cpu_types_pkg;

  localparam int CPU_SEL_W  = 5;
  localparam int CPU_DATA_W = 32;

  typedef logic [CPU_SEL_W-1:0]  regbits_t;
  typedef logic [CPU_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_seq_if.sv
// Beat stream from the register dump sequencer to a debug sink.
//   out_valid : beat available (source -> sink)
//   out_ready : sink accepts beat (sink -> source)
//   out_idx   : register index of the beat
//   out_data  : captured register value
// master = sequencer side, slave = sink side.
interface regfile_dump_seq_if #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_idx, output out_data, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/regfile_dump_seq.sv
// Register file read-side dump sequencer. Walks the second read port over a
// wrap-around range first_sel..last_sel and streams (index, data) beats.
//   CLK, nRST            : clock, asynchronous active-low reset
//   start, abort         : begin a dump (IDLE only) / cancel a dump
//   first_sel, last_sel  : range bounds, latched when start is accepted
//   rsel, rdat           : register file read port 2 (combinational read)
//   busy, done           : not-IDLE flag / one-cycle end-of-dump pulse
//   dump                 : beat stream (valid/ready, idx, data)
module regfile_dump_seq
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic [SEL_W-1:0]  rsel,
  input  logic [DATA_W-1:0] rdat,
  output logic              busy,
  output logic              done,
  regfile_dump_seq_if.master dump
);

  dump_state_t       state_q, state_d;
  logic [SEL_W-1:0]  idx_q, last_q, out_idx_q;
  logic [DATA_W-1:0] out_data_q;
  logic              xfer;
  logic [SEL_W-1:0]  idx_next;

  assign xfer     = (state_q == SEND) && dump.out_ready;
  assign idx_next = (idx_q == SEL_W'(NREGS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    rsel           = '0;
    dump.out_valid = 1'b0;
    busy           = (state_q != IDLE);
    done           = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = READ;
      READ: begin
        rsel    = idx_q;
        state_d = abort ? IDLE : SEND;
      end
      SEND: begin
        rsel           = idx_q;
        dump.out_valid = 1'b1;
        // abort overrides the handshake outcome; the beat itself still transfers
        if (abort)     state_d = IDLE;
        else if (xfer) state_d = (idx_q == last_q) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          idx_q  <= first_sel;
          last_q <= last_sel;
        end
        READ: begin
          out_idx_q  <= idx_q;
          out_data_q <= rdat;
        end
        SEND: if (xfer && !abort && idx_q != last_q) idx_q <= idx_next;
        default: ;
      endcase
    end
  end

  assign dump.out_idx  = out_idx_q;
  assign dump.out_data = out_data_q;

endmodule

// File: tb/tb_regfile_dump_seq.sv
module tb_regfile_dump_seq;
  import cpu_types_pkg::*;

  typedef struct {
    regbits_t idx;
    word_t    data;
  } beat_t;

  logic     CLK = 1'b0;
  logic     nRST = 1'b0;
  logic     start = 1'b0, abort = 1'b0;
  regbits_t first_sel = '0, last_sel = '0;
  regbits_t rsel;
  word_t    rdat;
  logic     busy, done;

  // register file model
  word_t    regs [32];
  logic     wen = 1'b0;
  regbits_t wsel = '0;
  word_t    wdat = '0;

  regfile_dump_seq_if #(.SEL_W(5), .DATA_W(32)) dif ();

  regfile_dump_seq #(.NREGS(32), .SEL_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .abort(abort),
    .first_sel(first_sel), .last_sel(last_sel),
    .rsel(rsel), .rdat(rdat), .busy(busy), .done(done), .dump(dif)
  );

  always #5 CLK = ~CLK;

  assign rdat = regs[rsel];
  always @(posedge CLK) if (wen) regs[wsel] <= wdat;

  int    checks = 0, failures = 0;
  int    done_seen = 0;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: scoreboard pops, stall stability, done counting
  logic     stall_prev = 1'b0;
  regbits_t hold_idx, hold_rsel;
  word_t    hold_data;

  always @(negedge CLK) begin
    if (nRST) begin
      if (done) done_seen++;
      if (dif.out_valid) begin
        chk("rsel_eq_idx", 64'(rsel), 64'(dif.out_idx));
        if (stall_prev) begin
          chk("stall_idx", 64'(dif.out_idx), 64'(hold_idx));
          chk("stall_data", 64'(dif.out_data), 64'(hold_data));
          chk("stall_rsel", 64'(rsel), 64'(hold_rsel));
        end
        if (dif.out_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(dif.out_idx), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            chk("beat_idx", 64'(dif.out_idx), 64'(b.idx));
            chk("beat_data", 64'(dif.out_data), 64'(b.data));
          end
        end else begin
          stall_prev = 1'b1;
          hold_idx   = dif.out_idx;
          hold_data  = dif.out_data;
          hold_rsel  = rsel;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input regbits_t s, input word_t d);
    wen = 1'b1; wsel = s; wdat = d;
    tick();
    wen = 1'b0;
  endtask

  // expected beats from the range rule: first, first+1, ... mod 32, through last
  task automatic do_start(input regbits_t f, input regbits_t l);
    int n;
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.idx  = regbits_t'((int'(f) + k) % 32);
      b.data = regs[b.idx];
      exp_q.push_back(b);
    end
    start = 1'b1; first_sel = f; last_sel = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic rand_rdy);
    int d0, c;
    d0 = done_seen;
    c  = 0;
    while (done_seen == d0 && c < budget) begin
      if (rand_rdy) dif.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    chk("done_within_budget", 64'(done_seen - d0), 64'd1);
    dif.out_ready = 1'b1;
    tick();
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, d0;
    dif.out_ready = 1'b1;
    #1;
    // reset state
    chk("rst_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rsel", 64'(rsel), 64'd0);
    chk("rst_idx", 64'(dif.out_idx), 64'd0);
    chk("rst_data", 64'(dif.out_data), 64'd0);
    repeat (2) tick();
    nRST = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) write_reg(regbits_t'(i), word_t'(i * 32'h11));

    // full dump with latency and total-length checks
    do_start(5'd0, 5'd31);
    chk("lat_read_valid", 64'(dif.out_valid), 64'd0);
    chk("lat_read_busy", 64'(busy), 64'd1);
    chk("lat_read_rsel", 64'(rsel), 64'd0);
    tick();
    cnt = 1;
    chk("lat_send_valid", 64'(dif.out_valid), 64'd1);
    while (!done && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("full_start_to_done", 64'(cnt), 64'd64);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("full_queue", 64'(exp_q.size()), 64'd0);

    // wrap range, with an ignored start while busy
    do_start(5'd30, 5'd1);
    repeat (2) tick();
    start = 1'b1; first_sel = 5'd3; last_sel = 5'd20;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0);

    // backpressure in the first SEND
    dif.out_ready = 1'b0;
    do_start(5'd2, 5'd5);
    tick();
    repeat (5) begin
      chk("bp_valid", 64'(dif.out_valid), 64'd1);
      chk("bp_rsel", 64'(rsel), 64'd2);
      tick();
    end
    dif.out_ready = 1'b1;
    wait_done(100, 1'b0);

    // write collision in the READ cycle
    do_start(5'd7, 5'd7);
    write_reg(5'd7, 32'hDEAD);
    wait_done(50, 1'b0);
    do_start(5'd7, 5'd7);
    wait_done(50, 1'b0);

    // abort during SEND of idx 4
    d0 = done_seen;
    do_start(5'd0, 5'd31);
    cnt = 0;
    while (!(dif.out_valid && dif.out_idx == 5'd3) && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    dif.out_ready = 1'b0;
    tick();
    chk("abort_at_idx4", 64'(dif.out_idx), 64'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_valid", 64'(dif.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rsel", 64'(rsel), 64'd0);
    repeat (3) tick();
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    dif.out_ready = 1'b1;
    do_start(5'd9, 5'd9);
    start = 1'b1; first_sel = 5'd0; last_sel = 5'd15;
    tick();
    start = 1'b0;
    wait_done(50, 1'b0);

    // asynchronous reset mid-dump
    d0 = done_seen;
    dif.out_ready = 1'b0;
    do_start(5'd10, 5'd12);
    tick();
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 64'(dif.out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rsel", 64'(rsel), 64'd0);
    chk("arst_data", 64'(dif.out_data), 64'd0);
    chk("arst_idx", 64'(dif.out_idx), 64'd0);
    repeat (2) tick();
    nRST = 1'b1;
    dif.out_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 64'(busy), 64'd0);
    chk("post_rst_valid", 64'(dif.out_valid), 64'd0);
    chk("post_rst_no_done", 64'(done_seen - d0), 64'd0);

    // randomized dumps with random backpressure; first one also tests abort+start in IDLE
    for (int it = 0; it < 10; it++) begin
      regbits_t f, l;
      repeat (4) write_reg(regbits_t'($urandom_range(0, 31)), word_t'($urandom));
      f = regbits_t'($urandom_range(0, 31));
      l = regbits_t'($urandom_range(0, 31));
      if (it == 0) abort = 1'b1;
      do_start(f, l);
      abort = 1'b0;
      wait_done(400, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_seq.md
Name: regfile_dump_seq

Overview:
- Read-side sequencer for the register file: walks the second read port over a contiguous, wrap-around range of register selects.
- Captures each word and streams it out as (index, data) beats over a valid/ready handshake.
- Sits between the register file and a debug sink (LED/7-seg pager, UART framer); the dual of the switch-driven write path.

Parameters:
- NREGS, 32, number of architectural registers (power of two).
- SEL_W, 5, select width = log2(NREGS).
- DATA_W, 32, register word width.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress dump.
- first_sel  input  SEL_W  first register of range, latched on accepted start.
- last_sel  input  SEL_W  last register of range, latched on accepted start.
- rsel  output  SEL_W  drives register file rsel2.
- rdat  input  DATA_W  register file rdat2 (combinational read).
- out_valid  output  1  beat available.
- out_ready  input  1  sink accepts beat.
- out_idx  output  SEL_W  register index of current beat.
- out_data  output  DATA_W  captured register value.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (nRST low, asynchronous): state IDLE; rsel=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0; latched range cleared to 0.
- States: IDLE, READ, SEND, DONE.
- IDLE: on start=1, latch first_sel into idx and last_sel into last -> READ.
- READ (one cycle): rsel=idx; register out_data<=rdat and out_idx<=idx -> SEND. rsel holds idx in READ and SEND, and 0 in IDLE/DONE.
- SEND: out_valid=1. out_data/out_idx remain stable until the handshake.
- Handshake: a beat transfers on a cycle with out_valid and out_ready both high.
  - If idx==last: go to DONE.
  - Otherwise: idx<=idx+1 modulo NREGS, then go to READ.
  - out_valid drops the cycle after transfer; no back-to-back beats; throughput is 1 word per 2 cycles at best.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start accepted at edge 0 -> READ during cycle 1 -> out_valid high in cycle 2.
- Range wrap: if first_sel>last_sel, the sequence runs first..NREGS-1, 0..last. Beats = ((last-first) mod NREGS)+1. first==last gives exactly 1 beat. first=0, last=NREGS-1 gives the full dump.
- start while busy: ignored, with no effect on the latched range.
- abort (any non-IDLE state): next state IDLE. out_valid deasserts the following cycle; done is not pulsed.
  - abort in the same cycle as a handshake: the beat counts as transferred, but abort wins and the state goes to IDLE.
  - abort in DONE: done still pulses this cycle.
  - abort and start together in IDLE: start wins.
- Concurrent writes: a write to register idx in the same cycle as READ is not observed. The captured value is the pre-edge content; later beats see post-write content.
- Register 0 reads as whatever the register file returns (0); no special casing.
- out_ready held low: SEND holds indefinitely with stable outputs.

Decomposition:
- Shared package cpu_types_pkg:
  - regbits_t (SEL_W-bit select) and word_t (DATA_W-bit word) typedefs.
  - New enum dump_state_t {IDLE, READ, SEND, DONE}.
- Single flat module; no sub-module is natural (FSM plus one wrapping counter).

Test Plan:
- Full dump: regs preloaded R[i]=i*0x11, first=0, last=31, out_ready=1 -> 32 beats idx 0..31, data i*0x11, out_valid first high 2 cycles after start, done pulse after beat 31, 64 cycles start->done.
- Wrap range: first=30, last=1 -> beats idx 30,31,0,1 in that order, then a single done.
- Backpressure: out_ready low for 5 cycles in the first SEND -> out_valid, out_idx, out_data held constant for the stall, no skipped index, rsel stable.
- Write collision: WEN with wsel=7, wdat=0xDEAD in the READ cycle for idx 7 (old value 0x77) -> beat 7 carries 0x77; a second dump of 7..7 returns 0xDEAD.
- Abort/restart: abort in SEND at idx 4 of a 0..31 dump -> IDLE next cycle, no done, busy=0. A new start with first=last=9 gives one beat idx 9 plus done. A start pulsed during busy has no effect.
- Async reset mid-dump: nRST low between clock edges in SEND -> immediately out_valid=0, busy=0, rsel=0, out_data=0; after release the block stays IDLE until start.
